rv_exec_unit: RTL and testbench
===============================

# rv_exec_unit

Multi-cycle execute unit for the RISC-V core: RV32I integer/immediate ALU ops, branch compare, load/store address generation, JAL link value, and the M-extension (MUL/MULH/MULHSU/MULHU, DIV/DIVU/REM/REMU).

- Sits between decode/register-read and writeback/memory.
- Replaces the combinational ALU with a registered, valid/ready-handshaked unit so the core can stall on long operations.
- Divide is iterative; all other operations complete in fixed short latency.

## Interface

Parameters
- WIDTH, default 32: datapath width. Must be a power of two, at least 8. SW = $clog2(WIDTH) is the shift-amount width.

Ports
- clk, input, 1: clock. All state updates on rising edge.
- rst, input, 1: reset, synchronous, active-high.
- in_valid, input, 1: operation presented.
- in_ready, output, 1: unit accepts an operation this cycle.
- pc, input, WIDTH: PC of the instruction.
- rs1, input, WIDTH: operand 1.
- rs2, input, WIDTH: operand 2.
- imm, input, 12: I- or S-immediate, already assembled by decode. Always sign-extended to WIDTH.
- shamt, input, SW: immediate shift amount.
- opcode, input, 7: instruction opcode.
- funct3, input, 3: instruction funct3.
- funct7, input, 7: instruction funct7.
- out_valid, output, 1: result available.
- out_ready, input, 1: consumer takes the result.
- rd, output, WIDTH: result value.
- mem_addr, output, WIDTH: load/store effective address.
- branch_taken, output, 1: branch condition result.

## Operation

- **Accept:** an operation is accepted when in_valid && in_ready at a rising edge. Operand inputs are ignored at all other times.
- **in_ready:** high only in state IDLE and low while rst is high. At most one operation is in flight.
- **FSM states:**
  - IDLE: accept → MUL, DIV, or OUT.
  - MUL: always → OUT after 1 cycle.
  - DIV: → OUT when the iteration counter reaches WIDTH−1.
  - OUT: out_valid=1; → IDLE on out_ready.
- **Opcode 0110011, funct7=0x00 or 0x20 (R-type):**
  - ADD/SUB: SUB only when funct7=0x20.
  - SLL and SRL/SRA: SRA when funct7=0x20. Shift amount is rs2[SW-1:0].
  - SLT is signed; SLTU is unsigned.
  - XOR, OR, AND.
  - Next state OUT.
- **Opcode 0010011 (I-type):** same ops with sext(imm) as operand 2, with these differences:
  - ADDI never subtracts.
  - Shifts use shamt; SRAI when funct7=0x20.
  - SLTIU compares unsigned against sext(imm).
  - Next state OUT.
- **Opcode 0110011, funct7=0x01 (M-extension):**
  - funct3 0–3 select MUL, MULH, MULHSU, MULHU. Result is the low or high WIDTH bits of the 2·WIDTH product, with operands signed/unsigned per RISC-V. Goes through state MUL.
  - funct3 4–7 select DIV, DIVU, REM, REMU. Restoring divider, one quotient bit per cycle, WIDTH cycles in DIV. Signed ops divide magnitudes, then fix signs: quotient negative iff operand signs differ; remainder takes the sign of the dividend.
- **Divide special cases** (resolved at accept, next state OUT directly):
  - Divide by zero: quotient all ones; remainder = rs1.
  - Signed overflow (rs1 = most-negative, rs2 = −1): quotient = rs1; remainder 0.
- **Opcode 1100011 (branch):**
  - funct3 0/1/4/5/6/7 select BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - branch_taken is the condition; rd = {0…0, branch_taken}.
  - Other funct3 values: branch_taken=0.
- **Opcode 0000011 (load) and 0100011 (store):** mem_addr = rs1 + sext(imm), modulo 2^WIDTH; rd=0.
- **Opcode 1101111 (JAL):** rd = pc + 4, modulo 2^WIDTH.
- **Unknown opcode, or undefined funct7 on 0110011:** rd=0, mem_addr=0, branch_taken=0. Completes with ALU latency; never hangs.
- **Output hold:** rd, mem_addr and branch_taken are registered. They are stable from out_valid rising until the out_ready handshake, and hold their last values afterwards. For non-branch ops, branch_taken=0. For non-load/store ops, mem_addr=0.

## Timing

- **Reset values:** state IDLE, out_valid=0, rd=0, mem_addr=0, branch_taken=0, divider counter 0.
- **Reset mid-operation:** rst at any state (including DIV or OUT) → IDLE on the next edge. The in-flight result is discarded with no out_valid.
- **Latency** (accept edge N to out_valid high):
  - ALU/branch/address/JAL/divide special case: N+1.
  - MUL-group: N+2.
  - DIV-group: N+1+WIDTH.
- **Throughput:** the earliest next accept is the edge after the out_ready handshake, since in_ready rises when state returns to IDLE. A back-to-back ALU stream therefore sustains 1 op per 2 cycles with out_ready held high.
- **Backpressure:** out_valid stays high indefinitely while out_ready=0, and the outputs do not change.

## Test plan

- **Reset and ADD/SUB:** reset, then R-type ADD rs1=5, rs2=7. Required: rd=12 one cycle after accept, in_ready=0 while out_valid=1. Then SUB 5−7 → rd=0xFFFFFFFE.
- **Immediate, shift and compare ops:**
  - ADDI rs1=0, imm=0xFFF → rd=0xFFFFFFFF.
  - SRAI rs1=0x80000000, shamt=4 → rd=0xF8000000.
  - SLTU rs1=1, rs2=0xFFFFFFFF → rd=1.
  - SLT with the same operands → rd=0.
- **Multiply:**
  - MULHU rs1=rs2=0xFFFFFFFF → rd=0xFFFFFFFE at accept+2.
  - MULH rs1=−2, rs2=3 → rd=0xFFFFFFFF.
- **Divide:**
  - DIV −7/2 → rd=−3 at accept+33.
  - REM −7/2 → rd=−1.
  - DIVU x/0 → rd=0xFFFFFFFF at accept+1.
  - DIV 0x80000000/−1 → rd=0x80000000.
- **Branches, memory address, JAL:**
  - BGEU rs1=0xFFFFFFFF, rs2=1 → branch_taken=1.
  - Load rs1=0x1000, imm=0xFFC → mem_addr=0x0FFC.
  - JAL pc=0x20 → rd=0x24.
- **Backpressure and reset abort:**
  - Hold out_ready=0 for 5 cycles: rd/out_valid stable, in_valid ignored.
  - Assert rst 10 cycles into a DIV: out_valid never rises, and in_ready=1 one cycle after rst drops.

Source files
------------

// File: rtl/rv_exec_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : rv_exec_unit_if
// Description : Issue/result handshake bundle between register-read and the
//               execute unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface rv_exec_unit_if #(
  parameter int WIDTH = 32
) ();
  localparam int c_SW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] rs1;
  logic [WIDTH-1:0] rs2;
  logic [11:0]      imm;
  logic [c_SW-1:0]  shamt;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] rd;
  logic [WIDTH-1:0] mem_addr;
  logic             branch_taken;

  modport master (
    output in_valid, pc, rs1, rs2, imm, shamt, opcode, funct3, funct7, out_ready,
    input  in_ready, out_valid, rd, mem_addr, branch_taken
  );

  modport slave (
    input  in_valid, pc, rs1, rs2, imm, shamt, opcode, funct3, funct7, out_ready,
    output in_ready, out_valid, rd, mem_addr, branch_taken
  );
endinterface
`default_nettype wire

// File: rtl/rv_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : rv_exec_unit
// Description : Registered RV32IM execute unit: ALU, branch compare, address
//               generation, JAL link, 1-stage multiply, iterative divide.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  rv_exec_unit_if.slave bus
);
  localparam int         c_SW     = $clog2(WIDTH);
  localparam logic [6:0] c_OP_R   = 7'b0110011;
  localparam logic [6:0] c_OP_I   = 7'b0010011;
  localparam logic [6:0] c_OP_B   = 7'b1100011;
  localparam logic [6:0] c_OP_LD  = 7'b0000011;
  localparam logic [6:0] c_OP_ST  = 7'b0100011;
  localparam logic [6:0] c_OP_JAL = 7'b1101111;
  localparam logic [WIDTH-1:0] c_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] c_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_OUT = 2'd3} state_t;

  state_t           r_state, w_next, w_route;
  logic             w_in_ready, w_out_valid, w_accept;
  logic [WIDTH-1:0] r_rd, r_ma, r_a, r_b, r_quo, r_rem, r_dvs;
  logic             r_br, r_neg_q, r_neg_r;
  logic [2:0]       r_f3;
  logic [c_SW-1:0]  r_cnt;

  logic [WIDTH-1:0] w_imm_sx, w_op2, w_alu, w_rd, w_ma;
  logic [c_SW-1:0]  w_amt;
  logic             w_is_i, w_sub, w_br, w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;

  // Decode and single-cycle results, evaluated from the presented operands
  always_comb begin
    w_imm_sx = WIDTH'($signed(bus.imm));
    w_is_i   = (bus.opcode == c_OP_I);
    w_op2    = w_is_i ? w_imm_sx : bus.rs2;
    w_amt    = w_is_i ? bus.shamt : bus.rs2[c_SW-1:0];
    w_sub    = !w_is_i && (bus.funct7 == 7'h20);
    w_alu    = '0;
    case (bus.funct3)
      3'd0: w_alu = w_sub ? bus.rs1 - w_op2 : bus.rs1 + w_op2;
      3'd1: w_alu = bus.rs1 << w_amt;
      3'd2: w_alu = WIDTH'($signed(bus.rs1) < $signed(w_op2));
      3'd3: w_alu = WIDTH'(bus.rs1 < w_op2);
      3'd4: w_alu = bus.rs1 ^ w_op2;
      3'd5: w_alu = (bus.funct7 == 7'h20) ? WIDTH'($signed(bus.rs1) >>> w_amt)
                                          : bus.rs1 >> w_amt;
      3'd6: w_alu = bus.rs1 | w_op2;
      default: w_alu = bus.rs1 & w_op2;
    endcase

    w_a_neg = !bus.funct3[0] && bus.rs1[WIDTH-1];
    w_b_neg = !bus.funct3[0] && bus.rs2[WIDTH-1];
    w_a_mag = w_a_neg ? -bus.rs1 : bus.rs1;
    w_b_mag = w_b_neg ? -bus.rs2 : bus.rs2;

    w_rd    = '0;
    w_ma    = '0;
    w_br    = 1'b0;
    w_route = S_OUT;
    case (bus.opcode)
      c_OP_R: begin
        if (bus.funct7 == 7'h00 || bus.funct7 == 7'h20) begin
          w_rd = w_alu;
        end else if (bus.funct7 == 7'h01) begin
          if (!bus.funct3[2]) begin
            w_route = S_MUL;
          end else if (bus.rs2 == '0) begin
            w_rd = bus.funct3[1] ? bus.rs1 : c_ONES;
          end else if (!bus.funct3[0] && bus.rs1 == c_MIN && bus.rs2 == c_ONES) begin
            w_rd = bus.funct3[1] ? '0 : bus.rs1;
          end else begin
            w_route = S_DIV;
          end
        end
      end
      c_OP_I: w_rd = w_alu;
      c_OP_B: begin
        case (bus.funct3)
          3'd0:    w_br = (bus.rs1 == bus.rs2);
          3'd1:    w_br = (bus.rs1 != bus.rs2);
          3'd4:    w_br = ($signed(bus.rs1) <  $signed(bus.rs2));
          3'd5:    w_br = ($signed(bus.rs1) >= $signed(bus.rs2));
          3'd6:    w_br = (bus.rs1 <  bus.rs2);
          3'd7:    w_br = (bus.rs1 >= bus.rs2);
          default: w_br = 1'b0;
        endcase
        w_rd = WIDTH'(w_br);
      end
      c_OP_LD, c_OP_ST: w_ma = bus.rs1 + w_imm_sx;
      c_OP_JAL:         w_rd = bus.pc + WIDTH'(4);
      default: ;
    endcase
  end

  // Multiply: operands are extended to 2*WIDTH so one unsigned product covers all signedness mixes
  logic [2*WIDTH-1:0] w_a_ext, w_b_ext, w_prod;
  logic [WIDTH-1:0]   w_mul_res;
  always_comb begin
    w_a_ext   = {{WIDTH{(r_f3[1:0] != 2'd3) && r_a[WIDTH-1]}}, r_a};
    w_b_ext   = {{WIDTH{!r_f3[1] && r_b[WIDTH-1]}}, r_b};
    w_prod    = w_a_ext * w_b_ext;
    w_mul_res = (r_f3[1:0] == 2'd0) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];
  end

  // Restoring divide step: partial remainder shifted with the next dividend bit
  logic [WIDTH:0]   w_shift, w_diff;
  logic             w_qbit;
  logic [WIDTH-1:0] w_rem_next, w_quo_fin, w_div_res;
  always_comb begin
    w_shift    = {r_rem, r_quo[WIDTH-1]};
    w_diff     = w_shift - {1'b0, r_dvs};
    w_qbit     = !w_diff[WIDTH];
    w_rem_next = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    w_quo_fin  = {r_quo[WIDTH-2:0], w_qbit};
    w_div_res  = r_f3[1] ? (r_neg_r ? -w_rem_next : w_rem_next)
                         : (r_neg_q ? -w_quo_fin  : w_quo_fin);
  end

  always_comb begin
    w_next      = r_state;
    w_in_ready  = (r_state == S_IDLE) && !rst;
    w_out_valid = (r_state == S_OUT);
    w_accept    = w_in_ready && bus.in_valid;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_route;
      S_MUL:   w_next = S_OUT;
      S_DIV:   if (r_cnt == c_SW'(WIDTH-1)) w_next = S_OUT;
      S_OUT:   if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd <= '0; r_ma <= '0; r_br <= 1'b0; r_cnt <= '0;
      r_a <= '0; r_b <= '0; r_f3 <= '0;
      r_quo <= '0; r_rem <= '0; r_dvs <= '0; r_neg_q <= 1'b0; r_neg_r <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_rd    <= w_rd;
          r_ma    <= w_ma;
          r_br    <= w_br;
          r_a     <= bus.rs1;
          r_b     <= bus.rs2;
          r_f3    <= bus.funct3;
          r_quo   <= w_a_mag;
          r_dvs   <= w_b_mag;
          r_rem   <= '0;
          r_neg_q <= w_a_neg ^ w_b_neg;
          r_neg_r <= w_a_neg;
          r_cnt   <= '0;
        end
        S_MUL: r_rd <= w_mul_res;
        S_DIV: begin
          r_quo <= w_quo_fin;
          r_rem <= w_rem_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_SW'(WIDTH-1)) r_rd <= w_div_res;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = w_out_valid;
  assign bus.rd           = r_rd;
  assign bus.mem_addr     = r_ma;
  assign bus.branch_taken = r_br;
endmodule
`default_nettype wire

// File: tb/tb_rv_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_exec_unit
// Description : Directed-vector bench with expected-result queue and monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_exec_unit;
  localparam logic [6:0] c_R = 7'b0110011, c_I = 7'b0010011, c_B = 7'b1100011;
  localparam logic [6:0] c_LD = 7'b0000011, c_ST = 7'b0100011, c_JAL = 7'b1101111;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic [31:0] ma;
    logic        br;
    int          lat;
    time         t;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  exp_t q[$];
  bit   seen = 1'b0;

  rv_exec_unit_if #(.WIDTH(32)) bus ();
  rv_exec_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: compare the presented result with the head of the queue
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          chk({q[0].name, "_latency"}, 32'(($time - q[0].t) / 10), 32'(q[0].lat));
          chk({q[0].name, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        chk({q[0].name, "_rd"}, bus.rd, q[0].rd);
        chk({q[0].name, "_mem_addr"}, bus.mem_addr, q[0].ma);
        chk({q[0].name, "_branch"}, 32'(bus.branch_taken), 32'(q[0].br));
        if (bus.out_ready) begin
          void'(q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic drive(input logic [31:0] pc, rs1, rs2, input logic [11:0] imm,
                       input logic [4:0] sh, input logic [6:0] opc,
                       input logic [2:0] f3, input logic [6:0] f7);
    bus.in_valid = 1'b1; bus.pc = pc; bus.rs1 = rs1; bus.rs2 = rs2; bus.imm = imm;
    bus.shamt = sh; bus.opcode = opc; bus.funct3 = f3; bus.funct7 = f7;
  endtask

  // Present one op, push its expectation at the accepting cycle, then withdraw it
  task automatic issue(input string name, input logic [31:0] pc, rs1, rs2,
                       input logic [11:0] imm, input logic [4:0] sh, input logic [6:0] opc,
                       input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] erd, ema, input logic ebr, input int lat);
    exp_t e;
    bit   ok = 1'b0;
    @(posedge clk); #1;
    drive(pc, rs1, rs2, imm, sh, opc, f3, f7);
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
    end
    if (!ok) begin
      chk({name, "_accept_timeout"}, 32'd0, 32'd1);
    end else begin
      e.name = name; e.rd = erd; e.ma = ema; e.br = ebr; e.lat = lat; e.t = $time;
      q.push_back(e);
      @(posedge clk);
    end
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
    chk({name, "_drain"}, 32'(q.size()), 32'd0);
  endtask

  initial begin
    int ov_cnt;
    bit ok;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("in_ready_in_reset", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_rd", bus.rd, 32'd0);
    chk("reset_mem_addr", bus.mem_addr, 32'd0);
    chk("reset_branch", 32'(bus.branch_taken), 32'd0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);

    //    name       pc     rs1           rs2           imm     sh  opc    f3  f7     rd            ma       br lat
    issue("add",     0, 32'd5,        32'd7,        12'h0,   0, c_R,   0, 7'h00, 32'd12,       0,       0, 1);
    issue("sub",     0, 32'd5,        32'd7,        12'h0,   0, c_R,   0, 7'h20, 32'hFFFFFFFE, 0,       0, 1);
    issue("addi",    0, 32'd0,        32'd99,       12'hFFF, 0, c_I,   0, 7'h7F, 32'hFFFFFFFF, 0,       0, 1);
    issue("srai",    0, 32'h80000000, 32'd0,        12'h404, 4, c_I,   5, 7'h20, 32'hF8000000, 0,       0, 1);
    issue("sltu",    0, 32'd1,        32'hFFFFFFFF, 12'h0,   0, c_R,   3, 7'h00, 32'd1,        0,       0, 1);
    issue("slt",     0, 32'd1,        32'hFFFFFFFF, 12'h0,   0, c_R,   2, 7'h00, 32'd0,        0,       0, 1);
    issue("sll",     0, 32'd1,        32'h23,       12'h0,   0, c_R,   1, 7'h00, 32'd8,        0,       0, 1);
    issue("xor",     0, 32'hA5A5A5A5, 32'hFFFF0000, 12'h0,   0, c_R,   4, 7'h00, 32'h5A5AA5A5, 0,       0, 1);
    issue("mulhu",   0, 32'hFFFFFFFF, 32'hFFFFFFFF, 12'h0,   0, c_R,   3, 7'h01, 32'hFFFFFFFE, 0,       0, 2);
    issue("mulh",    0, 32'hFFFFFFFE, 32'd3,        12'h0,   0, c_R,   1, 7'h01, 32'hFFFFFFFF, 0,       0, 2);
    issue("mul",     0, 32'h00010000, 32'h00010001, 12'h0,   0, c_R,   0, 7'h01, 32'h00010000, 0,       0, 2);
    issue("mulhsu",  0, 32'hFFFFFFFF, 32'hFFFFFFFF, 12'h0,   0, c_R,   2, 7'h01, 32'hFFFFFFFF, 0,       0, 2);
    issue("div",     0, 32'hFFFFFFF9, 32'd2,        12'h0,   0, c_R,   4, 7'h01, 32'hFFFFFFFD, 0,       0, 33);
    issue("rem",     0, 32'hFFFFFFF9, 32'd2,        12'h0,   0, c_R,   6, 7'h01, 32'hFFFFFFFF, 0,       0, 33);
    issue("divu",    0, 32'd100,      32'd7,        12'h0,   0, c_R,   5, 7'h01, 32'd14,       0,       0, 33);
    issue("remu",    0, 32'd100,      32'd7,        12'h0,   0, c_R,   7, 7'h01, 32'd2,        0,       0, 33);
    issue("divu_z",  0, 32'd5,        32'd0,        12'h0,   0, c_R,   5, 7'h01, 32'hFFFFFFFF, 0,       0, 1);
    issue("remu_z",  0, 32'd9,        32'd0,        12'h0,   0, c_R,   7, 7'h01, 32'd9,        0,       0, 1);
    issue("div_ovf", 0, 32'h80000000, 32'hFFFFFFFF, 12'h0,   0, c_R,   4, 7'h01, 32'h80000000, 0,       0, 1);
    issue("rem_ovf", 0, 32'h80000000, 32'hFFFFFFFF, 12'h0,   0, c_R,   6, 7'h01, 32'd0,        0,       0, 1);
    issue("bgeu",    0, 32'hFFFFFFFF, 32'd1,        12'h0,   0, c_B,   7, 7'h00, 32'd1,        0,       1, 1);
    issue("blt",     0, 32'hFFFFFFFF, 32'd1,        12'h0,   0, c_B,   4, 7'h00, 32'd1,        0,       1, 1);
    issue("beq",     0, 32'd3,        32'd4,        12'h0,   0, c_B,   0, 7'h00, 32'd0,        0,       0, 1);
    issue("load",    0, 32'h1000,     32'd0,        12'hFFC, 0, c_LD,  2, 7'h00, 32'd0,  32'h0FFC,     0, 1);
    issue("store",   0, 32'h10,       32'd5,        12'h010, 0, c_ST,  2, 7'h00, 32'd0,  32'h20,       0, 1);
    issue("jal",     32'h20, 32'd0,   32'd0,        12'h0,   0, c_JAL, 0, 7'h00, 32'h24,       0,       0, 1);
    issue("unk_op",  0, 32'd5,        32'd7,        12'h0,   0, 7'h7F, 0, 7'h00, 32'd0,        0,       0, 1);
    issue("bad_f7",  0, 32'd5,        32'd7,        12'h0,   0, c_R,   0, 7'h05, 32'd0,        0,       0, 1);
    drain("main");

    // Backpressure: result held while a competing op is presented and ignored
    bus.out_ready = 1'b0;
    issue("bp_add",  0, 32'd1,        32'd1,        12'h0,   0, c_R,   0, 7'h00, 32'd2,        0,       0, 1);
    drive(32'h40, 32'd0, 32'd0, 12'h0, 5'd0, c_JAL, 3'd0, 7'h00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain("bp");

    // Reset abort during a divide
    @(posedge clk); #1;
    drive(0, 32'd100, 32'd7, 12'h0, 5'd0, c_R, 3'd4, 7'h01);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
    end
    chk("abort_accept", 32'(ok), 32'd1);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    ov_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) ov_cnt++;
    end
    chk("abort_no_out_valid", 32'(ov_cnt), 32'd0);

    issue("post_abort", 0, 32'd20, 32'd22, 12'h0, 0, c_R, 0, 7'h00, 32'd42, 0, 0, 1);
    drain("post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
